vend_credit_sequencer: RTL and testbench

Credit/change controller for the vending machine. It accumulates inserted coins into a credit register that steps by 1 or 2 units per cycle. It arbitrates between purchase, cancel and coin events and sequences the dispense and change-return phases, emitting one change coin per cycle until credit reaches zero. It sits between the coin acceptor / keypad front-end and the dispenser and change-hopper drivers.

---
 rtl/vend_credit_sequencer.sv | 137 +++++++++++++
 tb/tb_vend_credit_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vend_credit_sequencer.sv
// vend_credit_sequencer: credit/change controller for the vending machine.
//
// Accumulates 1- and 2-unit coins into a credit register, arbitrates between
// cancel, select and coin events, and sequences a one-cycle dispense phase
// followed by a change-return phase that emits one change coin per cycle.
//
// Parameters:
//   W      credit register width; maximum credit is 2^W-1
//   PRICE  item price in units (1..2^W-1)
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   coin1/coin2  one-cycle pulses, 1-/2-unit coin inserted
//   select       purchase request (level)
//   cancel       abort and return all credit (level)
//   credit       current credit in units
//   dispense     one-cycle pulse, release one item
//   change1/2    one-cycle pulse, return one 1-/2-unit coin
//   coin_reject  one-cycle pulse, last coin not credited
//   busy         high while vending or returning change
// All outputs are registered.

module vend_credit_sequencer #(
  parameter int unsigned W     = 4,
  parameter int unsigned PRICE = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         coin1,
  input  logic         coin2,
  input  logic         select,
  input  logic         cancel,
  output logic [W-1:0] credit,
  output logic         dispense,
  output logic         change1,
  output logic         change2,
  output logic         coin_reject,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  localparam logic [W:0]   MaxC    = {1'b0, {W{1'b1}}};
  localparam logic [W:0]   CoinTwo = (W+1)'(2);
  localparam logic [W:0]   CoinOne = (W+1)'(1);
  localparam logic [W-1:0] PriceW  = W'(PRICE);
  localparam logic [W-1:0] Two     = W'(2);
  localparam logic [W-1:0] One     = W'(1);

  state_e       state;
  logic         coin_any;
  logic [W:0]   coin_val;
  logic [W:0]   sum;
  logic         coin_ok;
  logic         coin_rej;
  logic [W-1:0] remainder;
  logic [W-1:0] change_next;

  always_comb begin
    coin_any    = coin1 | coin2;
    coin_val    = coin2 ? CoinTwo : (coin1 ? CoinOne : '0);
    // W+1-bit sum so an overflowing coin is detected instead of wrapping.
    sum         = {1'b0, credit} + coin_val;
    coin_ok     = coin_any && (sum <= MaxC);
    // A simultaneous coin1 is always returned, even when coin2 is credited.
    coin_rej    = coin_any && ((sum > MaxC) || (coin1 && coin2));
    remainder   = credit - PriceW;
    change_next = (credit >= Two) ? credit - Two : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      credit      <= '0;
      dispense    <= 1'b0;
      change1     <= 1'b0;
      change2     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      change1     <= 1'b0;
      change2     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      unique case (state)
        StIdle, StCollect: begin
          if (state == StCollect && cancel) begin
            coin_reject <= coin_any;
            if (credit != '0) begin
              state <= StChange;
              busy  <= 1'b1;
            end else begin
              state <= StIdle;
            end
          end else if (state == StCollect && select && credit >= PriceW) begin
            coin_reject <= coin_any;
            state       <= StVend;
            dispense    <= 1'b1;
            busy        <= 1'b1;
          end else begin
            // IDLE ignores select/cancel; COLLECT falls through on low credit.
            coin_reject <= coin_rej;
            if (coin_ok) begin
              credit <= sum[W-1:0];
              state  <= StCollect;
            end
          end
        end
        StVend: begin
          coin_reject <= coin_any;
          credit      <= remainder;
          if (remainder != '0) begin
            state <= StChange;
            busy  <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        StChange: begin
          coin_reject <= coin_any;
          credit      <= change_next;
          change2     <= (credit >= Two);
          change1     <= (credit == One);
          if (change_next != '0) begin
            state <= StChange;
            busy  <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_sequencer.sv
// Directed testbench for vend_credit_sequencer (W=4, PRICE=6).
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that consumed them.

module tb_vend_credit_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin1 = 1'b0;
  logic       coin2 = 1'b0;
  logic       select = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] credit;
  logic       dispense;
  logic       change1;
  logic       change2;
  logic       coin_reject;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  vend_credit_sequencer #(.W(4), .PRICE(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .coin1      (coin1),
    .coin2      (coin2),
    .select     (select),
    .cancel     (cancel),
    .credit     (credit),
    .dispense   (dispense),
    .change1    (change1),
    .change2    (change2),
    .coin_reject(coin_reject),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and return on the next falling edge.
  task automatic cyc(input logic c1, input logic c2, input logic sel, input logic can);
    coin1  = c1;
    coin2  = c2;
    select = sel;
    cancel = can;
    @(negedge clk);
    coin1  = 1'b0;
    coin2  = 1'b0;
    select = 1'b0;
    cancel = 1'b0;
  endtask

  // Expected flags ordered dispense, change1, change2, coin_reject, busy.
  task automatic chk(input string tag, input logic [3:0] cr, input logic [4:0] fl);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {credit, dispense, change1, change2, coin_reject, busy};
    exp = {cr, fl};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed credit=%0d d/c1/c2/rej/busy=%b expected credit=%0d d/c1/c2/rej/busy=%b",
             tag, obs[8:5], obs[4:0], exp[8:5], exp[4:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    @(negedge clk);
    @(negedge clk);
    chk("por", 4'd0, 5'b00000);
    reset = 1'b0;

    // Exact payment
    cyc(0, 1, 0, 0); chk("exact_c2a", 4'd2, 5'b00000);
    cyc(0, 1, 0, 0); chk("exact_c2b", 4'd4, 5'b00000);
    cyc(0, 1, 0, 0); chk("exact_c2c", 4'd6, 5'b00000);
    cyc(0, 0, 1, 0); chk("exact_vend", 4'd6, 5'b10001);
    cyc(0, 0, 0, 0); chk("exact_done", 4'd0, 5'b00000);
    cyc(0, 0, 0, 0); chk("exact_idle", 4'd0, 5'b00000);

    // IDLE ignores cancel and select
    cyc(0, 0, 1, 1); chk("idle_ignore", 4'd0, 5'b00000);

    // Overpayment: 11 credit, change 5 -> 3, 1, 0
    for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 0);
    chk("over_10", 4'd10, 5'b00000);
    cyc(1, 0, 0, 0); chk("over_11", 4'd11, 5'b00000);
    cyc(0, 0, 1, 0); chk("over_vend", 4'd11, 5'b10001);
    cyc(0, 0, 0, 0); chk("over_rem", 4'd5, 5'b00001);
    cyc(0, 0, 0, 0); chk("over_chg_a", 4'd3, 5'b00101);
    cyc(0, 0, 0, 0); chk("over_chg_b", 4'd1, 5'b00101);
    cyc(0, 0, 0, 0); chk("over_chg_c", 4'd0, 5'b01000);
    cyc(0, 0, 0, 0); chk("over_idle", 4'd0, 5'b00000);

    // Overflow at the top of the range
    for (int i = 1; i <= 7; i++) cyc(0, 1, 0, 0);
    chk("ovf_14", 4'd14, 5'b00000);
    cyc(0, 1, 0, 0); chk("ovf_rej", 4'd14, 5'b00010);
    cyc(1, 0, 0, 0); chk("ovf_15", 4'd15, 5'b00000);
    cyc(1, 0, 0, 0); chk("ovf_rej1", 4'd15, 5'b00010);
    cyc(0, 0, 0, 1); chk("ovf_cancel", 4'd15, 5'b00001);
    for (int k = 13; k >= 1; k -= 2) begin
      cyc(0, 0, 0, 0); chk("ovf_drain", 4'(k), 5'b00101);
    end
    cyc(0, 0, 0, 0); chk("ovf_last", 4'd0, 5'b01000);

    // Simultaneous coins from credit 3
    cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); chk("sim_3", 4'd3, 5'b00000);
    cyc(1, 1, 0, 0); chk("sim_both", 4'd5, 5'b00010);
    cyc(0, 0, 0, 1); chk("sim_cancel", 4'd5, 5'b00001);
    cyc(0, 0, 0, 0); chk("sim_chg_a", 4'd3, 5'b00101);
    cyc(0, 0, 0, 0); chk("sim_chg_b", 4'd1, 5'b00101);
    cyc(0, 0, 0, 0); chk("sim_chg_c", 4'd0, 5'b01000);

    // Priority: cancel beats select beats coin
    for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); chk("pri_7", 4'd7, 5'b00000);
    cyc(1, 0, 1, 1); chk("pri_all", 4'd7, 5'b00011);
    cyc(0, 0, 0, 0); chk("pri_chg_a", 4'd5, 5'b00101);
    cyc(0, 0, 0, 0); chk("pri_chg_b", 4'd3, 5'b00101);
    cyc(0, 0, 0, 0); chk("pri_chg_c", 4'd1, 5'b00101);
    cyc(0, 0, 0, 0); chk("pri_chg_d", 4'd0, 5'b01000);

    // Low-credit select ignored, coin still credited, then coin during VEND
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); chk("low_4", 4'd4, 5'b00000);
    cyc(0, 0, 1, 0); chk("low_sel", 4'd4, 5'b00000);
    cyc(0, 1, 1, 0); chk("low_sel_coin", 4'd6, 5'b00000);
    cyc(0, 0, 1, 0); chk("busy_vend", 4'd6, 5'b10001);
    cyc(0, 1, 0, 0); chk("busy_rej", 4'd0, 5'b00010);
    cyc(0, 0, 0, 0); chk("busy_idle", 4'd0, 5'b00000);

    // Asynchronous reset during CHANGE at credit 3
    for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1); chk("rst_cancel", 4'd7, 5'b00001);
    cyc(0, 0, 0, 0); chk("rst_chg_a", 4'd5, 5'b00101);
    cyc(0, 0, 0, 0); chk("rst_chg_b", 4'd3, 5'b00101);
    #2 reset = 1'b1;
    #1 chk("rst_async", 4'd0, 5'b00000);
    @(negedge clk);
    chk("rst_hold", 4'd0, 5'b00000);
    reset = 1'b0;
    cyc(0, 0, 0, 0); chk("rst_quiet", 4'd0, 5'b00000);
    cyc(1, 0, 0, 0); chk("rst_coin1", 4'd1, 5'b00000);
    cyc(0, 1, 0, 0); chk("rst_coin2", 4'd3, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
